// File: rtl/prog_loader.sv
// Byte-stream program loader: parses SYNC/LEN/DATA/CSUM frames, writes the payload into
// instruction memory and keeps the CPU in reset until a frame has loaded with a good checksum.
module prog_loader #(
  parameter int unsigned      ADDR_W      = 5,
  parameter int unsigned      DATA_W      = 8,
  parameter logic [DATA_W-1:0] SYNC       = 8'hA5,
  parameter int unsigned      MAX_LEN     = 32,
  parameter bit               HOLD_AT_RST = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_req_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic              mem_wen_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              cpu_hold_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [1:0]        err_code_o
);

  // One extra bit so a full-size LEN (== 2**ADDR_W) is representable.
  localparam int unsigned LEN_W = ADDR_W + 1;

  localparam logic [1:0] ErrNone = 2'b00;
  localparam logic [1:0] ErrLen  = 2'b01;
  localparam logic [1:0] ErrCsum = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  state_e            r_state, w_state_nxt;
  logic [LEN_W-1:0]  r_len, w_len_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_sum, w_sum_nxt;
  logic              r_wen, w_wen_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic              r_hold, w_hold_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_err, w_err_nxt;
  logic [1:0]        r_code, w_code_nxt;

  logic              w_is_sync;
  logic              w_len_bad;
  logic              w_last_data;
  logic [DATA_W-1:0] w_sum_add;

  assign w_is_sync   = (in_data_i == SYNC);
  assign w_len_bad   = (in_data_i == '0) || (in_data_i > DATA_W'(MAX_LEN));
  assign w_last_data = ({1'b0, r_cnt} == (r_len - LEN_W'(1)));
  assign w_sum_add   = r_sum + in_data_i;

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_cnt_nxt   = r_cnt;
    w_sum_nxt   = r_sum;
    w_wen_nxt   = 1'b0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_hold_nxt  = r_hold;
    w_done_nxt  = r_done;
    w_err_nxt   = r_err;
    w_code_nxt  = r_code;

    if (load_req_i) begin
      // Abort wins over any byte presented this cycle; in_ready_o is low so nothing transfers.
      w_state_nxt = StIdle;
      w_hold_nxt  = 1'b1;
      w_done_nxt  = 1'b0;
      w_err_nxt   = 1'b0;
      w_code_nxt  = ErrNone;
    end else if (in_valid_i) begin
      case (r_state)
        StIdle, StDone, StErr: begin
          if (w_is_sync) begin
            w_state_nxt = StLen;
            w_hold_nxt  = 1'b1;
            w_done_nxt  = 1'b0;
            w_err_nxt   = 1'b0;
            w_code_nxt  = ErrNone;
          end
        end
        StLen: begin
          if (w_len_bad) begin
            w_state_nxt = StErr;
            w_err_nxt   = 1'b1;
            w_code_nxt  = ErrLen;
          end else begin
            w_state_nxt = StData;
            w_len_nxt   = LEN_W'(in_data_i);
            w_cnt_nxt   = '0;
            w_sum_nxt   = '0;
          end
        end
        StData: begin
          w_wen_nxt  = 1'b1;
          w_addr_nxt = r_cnt;
          w_data_nxt = in_data_i;
          w_sum_nxt  = w_sum_add;
          w_cnt_nxt  = r_cnt + ADDR_W'(1);
          if (w_last_data) begin
            w_state_nxt = StCsum;
          end
        end
        StCsum: begin
          if (w_sum_add == '0) begin
            w_state_nxt = StDone;
            w_done_nxt  = 1'b1;
            w_hold_nxt  = 1'b0;
          end else begin
            w_state_nxt = StErr;
            w_err_nxt   = 1'b1;
            w_code_nxt  = ErrCsum;
          end
        end
        default: begin
          w_state_nxt = StIdle;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt == StLen) || (w_state_nxt == StData) || (w_state_nxt == StCsum);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= StIdle;
      r_len   <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_hold  <= HOLD_AT_RST;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_code  <= ErrNone;
    end else begin
      r_state <= w_state_nxt;
      r_len   <= w_len_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sum   <= w_sum_nxt;
      r_wen   <= w_wen_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_hold  <= w_hold_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_code  <= w_code_nxt;
    end
  end

  assign in_ready_o = ~load_req_i;
  assign mem_wen_o  = r_wen;
  assign mem_addr_o = r_addr;
  assign mem_data_o = r_data;
  assign cpu_hold_o = r_hold;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign err_code_o = r_code;

endmodule

// File: tb/tb_prog_loader.sv
// Randomised self-checking bench for prog_loader against a byte-level frame model.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_req = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready_o, mem_wen_o, cpu_hold_o, busy_o, done_o, err_o;
  logic [4:0] mem_addr_o;
  logic [7:0] mem_data_o;
  logic [1:0] err_code_o;

  int n_total = 0;
  int n_bad   = 0;

  prog_loader dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .load_req_i (load_req),
    .in_data_i  (in_data),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready_o),
    .mem_wen_o  (mem_wen_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .cpu_hold_o (cpu_hold_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .err_code_o (err_code_o)
  );

  always #5 clk = ~clk;

  // Model: frame position (-1 = hunting for SYNC, 0 = LEN, 1..len = data, len+1 = checksum).
  int         m_pos;
  int         m_len;
  logic [7:0] m_q[$];
  logic       e_wen, e_hold, e_done, e_err, e_busy;
  logic [4:0] e_addr;
  logic [7:0] e_data;
  logic [1:0] e_code;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = -1; m_len = 0; m_q.delete();
    e_wen = 0; e_addr = 0; e_data = 0; e_hold = 1; e_done = 0; e_err = 0; e_busy = 0;
    e_code = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic r);
    int s;
    e_wen = 0;
    if (r) begin
      m_pos = -1; e_hold = 1; e_done = 0; e_err = 0; e_code = 0; e_busy = 0;
    end else if (v) begin
      if (m_pos < 0) begin
        if (d == 8'hA5) begin
          m_pos = 0; e_hold = 1; e_done = 0; e_err = 0; e_code = 0; e_busy = 1;
        end
      end else if (m_pos == 0) begin
        if (d == 0 || d > 32) begin
          m_pos = -1; e_err = 1; e_code = 2'b01; e_busy = 0;
        end else begin
          m_len = d; m_q.delete(); m_pos = 1;
        end
      end else if (m_pos <= m_len) begin
        e_wen = 1; e_addr = 5'(m_pos - 1); e_data = d; m_q.push_back(d); m_pos++;
      end else begin
        s = d;
        foreach (m_q[i]) s += m_q[i];
        if (s % 256 == 0) begin
          e_done = 1; e_hold = 0;
        end else begin
          e_err = 1; e_code = 2'b10;
        end
        e_busy = 0; m_pos = -1;
      end
    end
  endtask

  task automatic check_outputs(input string p);
    chk({p, "_wen"}, mem_wen_o, e_wen);
    chk({p, "_addr"}, mem_addr_o, e_addr);
    chk({p, "_data"}, mem_data_o, e_data);
    chk({p, "_hold"}, cpu_hold_o, e_hold);
    chk({p, "_busy"}, busy_o, e_busy);
    chk({p, "_done"}, done_o, e_done);
    chk({p, "_err"}, err_o, e_err);
    chk({p, "_code"}, err_code_o, e_code);
  endtask

  // One clock: drive on the falling edge, check in_ready_o, then check registers after the edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    in_valid = v; in_data = d; load_req = r;
    #1;
    chk("ready", in_ready_o, !r);
    model_step(v, d, r);
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  task automatic send(input logic [7:0] bytes[$]);
    foreach (bytes[i]) cyc(1'b1, bytes[i], 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
  endtask

  // Random frame; abort_at >= 0 raises load_req_i together with that byte index.
  task automatic send_frame(input int len, input bit bad_csum, input int abort_at);
    logic [7:0] b[$];
    logic [7:0] s;
    s = 0;
    b.push_back(8'hA5);
    b.push_back(8'(len));
    if (len >= 1 && len <= 32) begin
      for (int i = 0; i < len; i++) begin
        logic [7:0] x;
        x = ($urandom_range(0, 7) == 0) ? 8'hA5 : 8'($urandom);
        b.push_back(x);
        s = s + x;
      end
      s = -s;
      if (bad_csum) s = s + 8'($urandom_range(1, 255));
      b.push_back(s);
    end
    foreach (b[i]) begin
      if ($urandom_range(0, 3) == 0) cyc(1'b0, 8'($urandom), 1'b0);
      if (i == abort_at) begin
        cyc(1'b1, b[i], 1'b1);
        return;
      end
      cyc(1'b1, b[i], 1'b0);
    end
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] s;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame.
    send('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A});
    chk("t1_done", done_o, 1);
    chk("t1_hold", cpu_hold_o, 0);
    chk("t1_code", err_code_o, 0);

    // Bad checksum.
    send('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00});
    chk("t2_err", err_o, 1);
    chk("t2_code", err_code_o, 2'b10);
    chk("t2_hold", cpu_hold_o, 1);

    // Bad lengths.
    send('{8'hA5, 8'h00});
    chk("t3a_code", err_code_o, 2'b01);
    send('{8'hA5, 8'h21});
    chk("t3b_code", err_code_o, 2'b01);
    chk("t3_hold", cpu_hold_o, 1);

    // Maximum frame.
    q = '{8'hA5, 8'h20};
    s = 0;
    for (int i = 0; i < 32; i++) begin
      q.push_back(8'(i * 7 + 3));
      s = s + 8'(i * 7 + 3);
    end
    q.push_back(-s);
    foreach (q[i]) cyc(1'b1, q[i], 1'b0);
    chk("t4_done", done_o, 1);
    chk("t4_last_addr", mem_addr_o, 31);

    // Abort mid-DATA with valid held, then a clean frame.
    cyc(1'b1, 8'hA5, 1'b0); cyc(1'b1, 8'h04, 1'b0);
    cyc(1'b1, 8'h01, 1'b0); cyc(1'b1, 8'h02, 1'b0);
    cyc(1'b1, 8'h03, 1'b1);
    chk("t5_busy", busy_o, 0);
    chk("t5_wen", mem_wen_o, 0);
    cyc(1'b1, 8'h04, 1'b0);
    send('{8'hA5, 8'h02, 8'h40, 8'h41, 8'h7F});
    chk("t5_done", done_o, 1);

    // Stray bytes, SYNC as data.
    send('{8'h00, 8'hFF, 8'hA5, 8'h02, 8'hA5, 8'h01, 8'h5A});
    chk("t6_done", done_o, 1);
    chk("t6_data", mem_data_o, 8'h01);

    // Async reset mid-DATA.
    send_frame(8, 0, 4);
    cyc(1'b1, 8'hA5, 1'b0); cyc(1'b1, 8'h05, 1'b0); cyc(1'b1, 8'h33, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h44;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("arst");
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;

    // Randomised frames.
    for (int f = 0; f < 60; f++) begin
      int kind;
      int len;
      kind = $urandom_range(0, 9);
      repeat ($urandom_range(0, 2)) begin
        logic [7:0] x;
        x = 8'($urandom);
        if (x == 8'hA5) x = 8'h00;
        cyc(1'b1, x, 1'b0);
      end
      if (kind == 0) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(33, 255);
      else len = $urandom_range(1, 32);
      send_frame(len, kind == 1, (kind == 2) ? $urandom_range(1, len + 2) : -1);
    end
    cyc(1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
